// File: rtl/link_frame_scheduler.sv
// link_frame_scheduler: round-robin arbiter feeding a framed serializer (sync 1010, payload MSB-first, idle gap).
// Define LINK_PARITY_EN to compile in the PAR state, which appends one even-parity bit after the payload.
module link_frame_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int GAP_BITS  = 2
) (
  input  logic                         t_clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] payload,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic                         data_out,
  output logic                         frame_done,
  output logic [$clog2(NUM_REQ)-1:0]   last_src
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PAYLOAD_W) + 1;

`ifdef LINK_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif

  state_t               state, state_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [PAYLOAD_W-1:0] shift_reg, shift_n;
  logic [SRC_W-1:0]     ptr, ptr_n;
  logic [NUM_REQ-1:0]   gnt_n;
  logic                 busy_n, data_n, fd_n;
  logic [SRC_W-1:0]     last_src_n;
  logic [SRC_W-1:0]     winner, scan_idx;
  logic                 found;
  logic [PAYLOAD_W-1:0] win_payload;
`ifdef LINK_PARITY_EN
  logic                 par_bit, par_n;
`endif

  // Round-robin search starting at the pointer; first active requester wins.
  always_comb begin
    found       = 1'b0;
    winner      = '0;
    scan_idx    = '0;
    win_payload = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == SRC_W'(i)) win_payload = payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Outputs are registered: each state computes what the link shows in the following cycle.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    ptr_n      = ptr;
    gnt_n      = '0;
    busy_n     = busy;
    data_n     = 1'b0;
    fd_n       = 1'b0;
    last_src_n = last_src;
`ifdef LINK_PARITY_EN
    par_n      = par_bit;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          state_n    = SYNC;
          bit_cnt_n  = '0;
          shift_n    = win_payload;
          gnt_n      = NUM_REQ'(1) << winner;
          last_src_n = winner;
          ptr_n      = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          busy_n     = 1'b1;
          data_n     = 1'b1;
`ifdef LINK_PARITY_EN
          par_n      = ^win_payload;
`endif
        end
      end
      SYNC: begin
        if (bit_cnt == CNT_W'(3)) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          data_n    = shift_reg[PAYLOAD_W-1];
          shift_n   = shift_reg << 1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          data_n    = bit_cnt[0];
        end
      end
      DATA: begin
        if (bit_cnt == CNT_W'(PAYLOAD_W - 1)) begin
          bit_cnt_n = '0;
`ifdef LINK_PARITY_EN
          state_n   = PAR;
          data_n    = par_bit;
`else
          state_n   = GAP;
          fd_n      = 1'b1;
`endif
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          data_n    = shift_reg[PAYLOAD_W-1];
          shift_n   = shift_reg << 1;
        end
      end
`ifdef LINK_PARITY_EN
      PAR: begin
        state_n   = GAP;
        bit_cnt_n = '0;
        fd_n      = 1'b1;
      end
`endif
      GAP: begin
        if (bit_cnt == CNT_W'(GAP_BITS - 1)) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
          busy_n    = 1'b0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      ptr        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      data_out   <= 1'b0;
      frame_done <= 1'b0;
      last_src   <= '0;
`ifdef LINK_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      ptr        <= ptr_n;
      gnt        <= gnt_n;
      busy       <= busy_n;
      data_out   <= data_n;
      frame_done <= fd_n;
      last_src   <= last_src_n;
`ifdef LINK_PARITY_EN
      par_bit    <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_link_frame_scheduler.sv
// Scoreboard bench for link_frame_scheduler: expected frames are queued as requests are raised
// and compared bit-by-bit when the serializer emits them.
module tb_link_frame_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int PAYLOAD_W = 32;
  localparam int GAP_BITS  = 2;
  localparam int SRC_W     = $clog2(NUM_REQ);
`ifdef LINK_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 4 + PAYLOAD_W + PAR_BITS + GAP_BITS;
  localparam int PERIOD     = FRAME_BITS + 1;
  localparam int FD_POS     = 4 + PAYLOAD_W + PAR_BITS;

  typedef struct {
    int                   src;
    logic [PAYLOAD_W-1:0] data;
  } exp_t;

  logic                         t_clk = 1'b0;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*PAYLOAD_W-1:0] payload;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic                         data_out;
  logic                         frame_done;
  logic [SRC_W-1:0]             last_src;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  link_frame_scheduler #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .GAP_BITS(GAP_BITS)) dut (
    .t_clk(t_clk), .rst_n(rst_n), .req(req), .payload(payload), .gnt(gnt),
    .busy(busy), .data_out(data_out), .frame_done(frame_done), .last_src(last_src)
  );

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FRAME_BITS-1:0] exp_stream(input logic [PAYLOAD_W-1:0] d);
    logic [FRAME_BITS-1:0] s;
    s = '0;
    s[FRAME_BITS-1 -: 4]         = 4'b1010;
    s[FRAME_BITS-5 -: PAYLOAD_W] = d;
`ifdef LINK_PARITY_EN
    s[GAP_BITS] = ^d;
`endif
    return s;
  endfunction

  task automatic set_payload(input int i, input logic [PAYLOAD_W-1:0] v);
    payload[i*PAYLOAD_W +: PAYLOAD_W] = v;
  endtask

  task automatic do_reset();
    @(negedge t_clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge t_clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, then records one whole frame plus the following IDLE cycle.
  task automatic capture_frame(input logic [NUM_REQ-1:0] rel_mask, output bit got,
                               output logic [NUM_REQ-1:0] g, output logic [SRC_W-1:0] src,
                               output logic [FRAME_BITS-1:0] bits, output int fd_pos,
                               output int fd_cnt, output bit busy_ok, output bit gnt_once,
                               output int t_gnt);
    int n;
    got = 0; g = '0; src = '0; bits = '0; fd_pos = -1; fd_cnt = 0;
    busy_ok = 1; gnt_once = 1; t_gnt = -1; n = 0;
    while (!got && n < 200) begin
      @(negedge t_clk);
      n++;
      if (gnt != '0) got = 1;
    end
    if (!got) return;
    g     = gnt;
    src   = last_src;
    t_gnt = cyc;
    req   = req & ~rel_mask;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i > 0) @(negedge t_clk);
      bits[FRAME_BITS-1-i] = data_out;
      if (frame_done === 1'b1) begin fd_cnt++; fd_pos = i; end
      if (busy !== 1'b1) busy_ok = 0;
      if (i > 0 && gnt !== '0) gnt_once = 0;
    end
    @(negedge t_clk);
    if (busy !== 1'b0 || frame_done !== 1'b0) busy_ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; payload = '0;
    repeat (3) @(negedge t_clk);
    checks++; if (data_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_out got %b required 0", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b required 0", busy); end
    checks++; if (gnt !== '0) begin failures++; $display("[TB] FAIL reset_gnt got %b required 0", gnt); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got %b required 0", frame_done); end
    checks++; if (last_src !== '0) begin failures++; $display("[TB] FAIL reset_last_src got %0d required 0", last_src); end
    rst_n = 1'b1;
    @(negedge t_clk);
  endtask

  task automatic test_single();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg; exp_t e;
    set_payload(0, 32'hA5C3_0F81);
    req = 4'b0001;
    sb.push_back('{0, 32'hA5C3_0F81});
    capture_frame(4'b1111, got, g, s, b, fp, fc, bok, gone, tg);
    e = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("[TB] FAIL single_timeout no gnt, required gnt for src %0d", e.src); end
    else begin
      checks++; if (g !== (NUM_REQ'(1) << e.src)) begin failures++; $display("[TB] FAIL single_gnt got %b required %b", g, NUM_REQ'(1) << e.src); end
      checks++; if (s !== SRC_W'(e.src)) begin failures++; $display("[TB] FAIL single_last_src got %0d required %0d", s, e.src); end
      checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL single_stream got %b required %b", b, exp_stream(e.data)); end
      checks++; if (fc !== 1 || fp !== FD_POS) begin failures++; $display("[TB] FAIL single_frame_done got count %0d pos %0d required count 1 pos %0d", fc, fp, FD_POS); end
      checks++; if (bok !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got window-mismatch required high through gap then low"); end
      checks++; if (gone !== 1'b1) begin failures++; $display("[TB] FAIL single_gnt_pulse got gnt beyond one cycle required single pulse"); end
    end
  endtask

  task automatic test_round_robin();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg, tprev; exp_t e;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_payload(i, 32'h1357_9BDF ^ (32'h1111_1111 * (i + 1)));
    req = 4'b1111;
    for (int f = 0; f < 5; f++) sb.push_back('{order[f], payload[order[f]*PAYLOAD_W +: PAYLOAD_W]});
    tprev = -1;
    for (int f = 0; f < 5; f++) begin
      capture_frame((f == 4) ? 4'b1111 : 4'b0000, got, g, s, b, fp, fc, bok, gone, tg);
      e = sb.pop_front();
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL rr_timeout frame %0d no gnt, required src %0d", f, e.src); end
      else begin
        checks++; if (s !== SRC_W'(e.src)) begin failures++; $display("[TB] FAIL rr_src frame %0d got %0d required %0d", f, s, e.src); end
        checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL rr_stream frame %0d got %b required %b", f, b, exp_stream(e.data)); end
        if (tprev >= 0) begin
          checks++; if (tg - tprev !== PERIOD) begin failures++; $display("[TB] FAIL rr_period frame %0d got %0d required %0d", f, tg - tprev, PERIOD); end
        end
      end
      tprev = tg;
    end
  endtask

  task automatic test_pointer();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg; exp_t e;
    logic [NUM_REQ-1:0] masks[4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    set_payload(0, 32'h0F0F_1234); set_payload(1, 32'hDEAD_BEEF); set_payload(3, 32'h8000_0001);
    req = 4'b1000;
    sb.push_back('{3, 32'h8000_0001});
    sb.push_back('{1, 32'hDEAD_BEEF});
    sb.push_back('{3, 32'h8000_0001});
    sb.push_back('{0, 32'h0F0F_1234});
    for (int f = 0; f < 4; f++) begin
      if (f == 1) begin
        req = 4'b1010;
        fork
          begin repeat (20) @(negedge t_clk); req[0] = 1'b1; end
        join_none
      end
      capture_frame(masks[f], got, g, s, b, fp, fc, bok, gone, tg);
      e = sb.pop_front();
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL ptr_timeout frame %0d no gnt, required src %0d", f, e.src); end
      else begin
        checks++; if (g !== (NUM_REQ'(1) << e.src)) begin failures++; $display("[TB] FAIL ptr_gnt frame %0d got %b required %b", f, g, NUM_REQ'(1) << e.src); end
        checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL ptr_stream frame %0d got %b required %b", f, b, exp_stream(e.data)); end
      end
    end
    req = '0;
  endtask

  task automatic test_payload_change();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg; exp_t e;
    do_reset();
    set_payload(2, 32'h3C5A_96E1);
    req = 4'b0100;
    sb.push_back('{2, 32'h3C5A_96E1});
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          @(negedge t_clk);
          if (gnt[2] === 1'b1) begin set_payload(2, 32'hC3A5_691E); break; end
        end
      end
    join_none
    capture_frame(4'b0100, got, g, s, b, fp, fc, bok, gone, tg);
    e = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("[TB] FAIL chg_timeout no gnt, required src %0d", e.src); end
    else begin
      checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL chg_stream got %b required %b", b, exp_stream(e.data)); end
    end
  endtask

  task automatic test_parity();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg; exp_t e;
    logic [PAYLOAD_W-1:0] vals[2] = '{32'h0000_0001, 32'h0000_0003};
    int srcs[2] = '{3, 0};
    do_reset();
    for (int f = 0; f < 2; f++) begin
      set_payload(srcs[f], vals[f]);
      req = NUM_REQ'(1) << srcs[f];
      sb.push_back('{srcs[f], vals[f]});
      capture_frame(4'b1111, got, g, s, b, fp, fc, bok, gone, tg);
      e = sb.pop_front();
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL par_timeout frame %0d no gnt, required src %0d", f, e.src); end
      else begin
        checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL par_stream frame %0d got %b required %b", f, b, exp_stream(e.data)); end
        checks++; if (fp !== FD_POS) begin failures++; $display("[TB] FAIL par_frame_done_pos frame %0d got %0d required %0d", f, fp, FD_POS); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got, bok, gone; logic [NUM_REQ-1:0] g; logic [SRC_W-1:0] s;
    logic [FRAME_BITS-1:0] b; int fp, fc, tg, seen_hi, seen_fd, n; exp_t e;
    do_reset();
    set_payload(1, 32'hFFFF_FFFF); set_payload(3, 32'h2468_ACE0);
    req = 4'b0010;
    n = 0;
    while (gnt !== 4'b0010 && n < 50) begin @(negedge t_clk); n++; end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL rst_mid_start got gnt %b required 0010", gnt); end
    req = '0;
    repeat (4 + 10) @(negedge t_clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 1'b0 || busy !== 1'b0 || gnt !== '0 || frame_done !== 1'b0 || last_src !== '0) begin
      failures++;
      $display("[TB] FAIL rst_mid_outputs got data %b busy %b gnt %b fd %b src %0d required all 0",
               data_out, busy, gnt, frame_done, last_src);
    end
    @(negedge t_clk);
    rst_n = 1'b1;
    seen_hi = 0; seen_fd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge t_clk);
      if (data_out !== 1'b0 || busy !== 1'b0) seen_hi++;
      if (frame_done !== 1'b0) seen_fd++;
    end
    checks++; if (seen_hi !== 0 || seen_fd !== 0) begin failures++; $display("[TB] FAIL rst_mid_silent got active %0d fd %0d required 0 0", seen_hi, seen_fd); end
    req = 4'b1010;
    sb.push_back('{1, 32'hFFFF_FFFF});
    capture_frame(4'b1111, got, g, s, b, fp, fc, bok, gone, tg);
    e = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("[TB] FAIL rst_mid_timeout no gnt, required src %0d", e.src); end
    else begin
      checks++; if (s !== SRC_W'(e.src)) begin failures++; $display("[TB] FAIL rst_mid_pointer got %0d required %0d", s, e.src); end
      checks++; if (b !== exp_stream(e.data)) begin failures++; $display("[TB] FAIL rst_mid_stream got %b required %b", b, exp_stream(e.data)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_payload_change();
    test_parity();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_frame_scheduler.md
# link_frame_scheduler

Shares one serial self-test link between `NUM_REQ` requesters. It arbitrates round-robin and captures the winner's parallel payload. It then serializes the payload as a framed bit stream: sync pattern `1010`, payload MSB-first, an optional parity bit, then an idle gap. Its output drives the serial input of the receive-side deserializer across the die-to-die test link.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PAYLOAD_W`, 32: payload bits per frame, multiple of 8.
- `GAP_BITS`, 2: idle-low bit times after each frame, ≥1.

Ports:
- `t_clk` in 1: link bit clock; one serial bit per cycle.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester frame request, level; held until matching `gnt`.
- `payload` in NUM_REQ*PAYLOAD_W: requester i's data in slice [i*PAYLOAD_W +: PAYLOAD_W]; must be stable while `req[i]` is high.
- `gnt` out NUM_REQ: one-hot, one-cycle pulse; the winner's payload was captured on the previous edge.
- `busy` out 1: high from the first sync bit through the last gap bit.
- `data_out` out 1: serial link bit, registered.
- `frame_done` out 1: one-cycle pulse in the first GAP cycle.
- `last_src` out $clog2(NUM_REQ): index of the most recently granted requester.

## Operation
- FSM states: IDLE, SYNC, DATA, PAR (only with the macro), GAP.
- IDLE: `data_out`=0, `busy`=0. If `req` is nonzero at an edge:
  - pick the winner;
  - load the shift register with its payload;
  - set `gnt[winner]`, `last_src`, and the first sync bit;
  - go to SYNC.
- SYNC: 4 cycles, `data_out` = 1,0,1,0; `bit_cnt` counts 0..3. The `gnt` pulse is visible in the first SYNC cycle.
- DATA: PAYLOAD_W cycles; `data_out` = shift_reg MSB; shift left each cycle.
- PAR: 1 cycle; `data_out` = XOR of all captured payload bits (even parity).
- GAP: GAP_BITS cycles with `data_out`=0. `frame_done` is high in the first GAP cycle. Then go to IDLE.
- Round-robin arbitration:
  - the priority pointer starts at index 0 after reset;
  - after a grant to i, search order is i+1, i+2, … wrapping modulo NUM_REQ;
  - a requester that keeps `req` high is served again only after all other active requesters.
- `req` changes during SYNC/DATA/PAR/GAP are ignored; arbitration happens only in IDLE.
- Frames are never back-to-back: at least GAP_BITS low cycles plus one IDLE cycle separate a frame's last payload/parity bit from the next frame's sync `1`.
- The payload is captured at grant. Requester payload changes after `gnt` do not affect the frame in flight.
- The bit counter is sized $clog2(PAYLOAD_W)+1 and wraps to 0 at every state transition.

## Timing
- Reset values (async, immediate): state IDLE, `data_out`=0, `busy`=0, `gnt`=0, `frame_done`=0, `last_src`=0, pointer=0, shift register=0.
- Latency: `req` high at edge k in IDLE means `data_out`=1 (first sync bit) and `gnt` high during cycle k+1.
- Frame period: 4+PAYLOAD_W+GAP_BITS cycles, plus 1 with parity, plus 1 IDLE arbitration cycle. Default is 39 cycles edge-to-edge, 40 with parity.
- `busy` falls in the cycle after the last GAP cycle (the IDLE cycle).
- Reset asserted mid-frame aborts the frame. After reset the link is silent until a new `req` is seen, and no `frame_done` is issued for the aborted frame.

## Configuration
- `LINK_PARITY_EN` defined: the PAR state is compiled in and one even-parity bit follows the payload.
- Not defined: no PAR state; GAP directly follows the last payload bit.

## Test plan
- Single request: `req`=0001, payload0=32'hA5C3_0F81. Expect `gnt`=0001 one cycle, `data_out` = 1010 then A5C30F81 MSB-first, then 2 zeros, `frame_done` once, `last_src`=0.
- All four request continuously: grants in order 0,1,2,3,0. Each frame is 39 cycles apart (40 with `LINK_PARITY_EN`).
- `req`=1010 with the pointer after a grant to 3: grant 1, then 3. A new `req[0]` raised mid-frame is ignored until IDLE.
- Parity build: payload 32'h0000_0001 gives parity bit 1; 32'h0000_0003 gives parity bit 0. Without the macro, no extra bit.
- Payload changed the cycle after `gnt`: the serialized bits equal the value captured at grant.
- `rst_n` pulsed low in DATA bit 10: outputs go to reset values immediately. The next `req` yields a full fresh frame starting with `1010`, and the pointer is back at 0.
